// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        LOCKED    = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    // Timer must hold the largest terminal count of any timed state.
    function automatic int timer_w(input int rst_cycles,
                                   input int timeout_cycles,
                                   input int stable_cycles);
        int m;
        m = rst_cycles;
        if (timeout_cycles > m) begin
            m = timeout_cycles;
        end else begin
            m = m;
        end
        if (stable_cycles > m) begin
            m = stable_cycles;
        end else begin
            m = m;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One supervised PLL channel: locked-flag synchroniser, reset/lock FSM,
// shared state timer, retry counter and saturating loss-of-lock counter.
module pll_lock_chan
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 64,
    parameter int LOCK_STABLE_CYCLES  = 16,
    parameter int MAX_RETRIES         = 3,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_locked_async,
    input  logic                  i_retry_clear,
    output logic                  o_pll_rst,
    output logic                  o_clk_ready,
    output logic                  o_fail,
    output logic [LOSS_CNT_W-1:0] o_loss_cnt
);

    localparam int TW = timer_w(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0]         RST_LAST  = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0]         TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]         STB_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0]         RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX  = {LOSS_CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] r_sync;
    pll_state_t             r_state;
    pll_state_t             w_state_nxt;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timer_nxt;
    logic [RW-1:0]          r_retries;
    logic [RW-1:0]          w_retries_nxt;
    logic [RW-1:0]          w_retry_inc;
    logic [LOSS_CNT_W-1:0]  r_loss;
    logic [LOSS_CNT_W-1:0]  w_loss_nxt;
    logic                   r_pll_rst;
    logic                   r_clk_ready;
    logic                   r_fail;
    logic                   w_lk;

    assign w_lk        = r_sync[SYNC_STAGES-1];
    assign w_retry_inc = r_retries + RW'(1);

    // Bring the asynchronous locked flag into the refclk domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked_async};
        end
    end

    // Next-state, timer, retry and loss-count decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_retries_nxt = r_retries;
        w_loss_nxt    = r_loss;
        case (r_state)
            RST_PLL: begin
                if (r_timer == RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as a lock.
                if (w_lk) begin
                    w_state_nxt = STABLE;
                    w_timer_nxt = '0;
                end else if (r_timer == TO_LAST) begin
                    w_retries_nxt = w_retry_inc;
                    w_timer_nxt   = '0;
                    if (w_retry_inc == RETRY_MAX) begin
                        w_state_nxt = FAIL;
                    end else begin
                        w_state_nxt = RST_PLL;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            STABLE: begin
                if (!w_lk) begin
                    w_state_nxt = WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == STB_LAST) begin
                    w_state_nxt = LOCKED;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            LOCKED: begin
                if (!w_lk) begin
                    w_state_nxt   = RST_PLL;
                    w_timer_nxt   = '0;
                    w_retries_nxt = '0;
                    if (r_loss != LOSS_MAX) begin
                        w_loss_nxt = r_loss + LOSS_CNT_W'(1);
                    end else begin
                        w_loss_nxt = r_loss;
                    end
                end else begin
                    w_state_nxt = LOCKED;
                end
            end
            FAIL: begin
                if (i_retry_clear) begin
                    w_state_nxt   = RST_PLL;
                    w_timer_nxt   = '0;
                    w_retries_nxt = '0;
                end else begin
                    w_state_nxt = FAIL;
                end
            end
            default: begin
                w_state_nxt   = RST_PLL;
                w_timer_nxt   = '0;
                w_retries_nxt = '0;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they align with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RST_PLL;
            r_timer     <= '0;
            r_retries   <= '0;
            r_loss      <= '0;
            r_pll_rst   <= 1'b1;
            r_clk_ready <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_retries   <= w_retries_nxt;
            r_loss      <= w_loss_nxt;
            r_pll_rst   <= (w_state_nxt == RST_PLL) || (w_state_nxt == FAIL);
            r_clk_ready <= (w_state_nxt == LOCKED);
            r_fail      <= (w_state_nxt == FAIL);
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_clk_ready = r_clk_ready;
    assign o_fail      = r_fail;
    assign o_loss_cnt  = r_loss;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Multi-channel PLL lock supervisor: independent channel supervisors plus
// a registered all-channels-ready summary.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLL             = 2,
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 64,
    parameter int LOCK_STABLE_CYCLES  = 16,
    parameter int MAX_RETRIES         = 3,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                          refclk,
    input  logic                          rst,
    input  logic [NUM_PLL-1:0]            pll_locked_in,
    input  logic [NUM_PLL-1:0]            retry_clear,
    output logic [NUM_PLL-1:0]            pll_rst,
    output logic [NUM_PLL-1:0]            clk_ready,
    output logic                          all_ready,
    output logic [NUM_PLL-1:0]            fail,
    output logic [NUM_PLL*LOSS_CNT_W-1:0] loss_cnt
);

    logic r_all_ready;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
        pll_lock_chan #(
            .SYNC_STAGES        (SYNC_STAGES),
            .PLL_RST_CYCLES     (PLL_RST_CYCLES),
            .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
            .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
            .MAX_RETRIES        (MAX_RETRIES),
            .LOSS_CNT_W         (LOSS_CNT_W)
        ) u_chan (
            .i_clk         (refclk),
            .i_rst         (rst),
            .i_locked_async(pll_locked_in[g]),
            .i_retry_clear (retry_clear[g]),
            .o_pll_rst     (pll_rst[g]),
            .o_clk_ready   (clk_ready[g]),
            .o_fail        (fail[g]),
            .o_loss_cnt    (loss_cnt[g*LOSS_CNT_W +: LOSS_CNT_W])
        );
    end

    // Summary flag follows the registered per-channel ready vector by one cycle.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_all_ready <= 1'b0;
        end else begin
            r_all_ready <= &clk_ready;
        end
    end

    assign all_ready = r_all_ready;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase/age reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_pll_lock_supervisor;

    localparam int NUM_PLL             = 2;
    localparam int SYNC_STAGES         = 2;
    localparam int PLL_RST_CYCLES      = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 64;
    localparam int LOCK_STABLE_CYCLES  = 16;
    localparam int MAX_RETRIES         = 3;
    localparam int LOSS_CNT_W          = 8;
    localparam int LOSS_SAT            = (1 << LOSS_CNT_W) - 1;
    localparam int MAXE                = 60000;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_LOCKED = 3;
    localparam int PH_FAIL   = 4;

    logic                          refclk = 1'b0;
    logic                          rst;
    logic [NUM_PLL-1:0]            pll_locked_in;
    logic [NUM_PLL-1:0]            retry_clear;
    logic [NUM_PLL-1:0]            pll_rst;
    logic [NUM_PLL-1:0]            clk_ready;
    logic                          all_ready;
    logic [NUM_PLL-1:0]            fail;
    logic [NUM_PLL*LOSS_CNT_W-1:0] loss_cnt;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .NUM_PLL            (NUM_PLL),
        .SYNC_STAGES        (SYNC_STAGES),
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .MAX_RETRIES        (MAX_RETRIES),
        .LOSS_CNT_W         (LOSS_CNT_W)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked_in(pll_locked_in),
        .retry_clear  (retry_clear),
        .pll_rst      (pll_rst),
        .clk_ready    (clk_ready),
        .all_ready    (all_ready),
        .fail         (fail),
        .loss_cnt     (loss_cnt)
    );

    typedef struct packed {
        logic [NUM_PLL-1:0]            prst;
        logic [NUM_PLL-1:0]            rdy;
        logic [NUM_PLL-1:0]            fl;
        logic                          all;
        logic [NUM_PLL*LOSS_CNT_W-1:0] loss;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_got;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: phase, cycles spent in phase, failed tries, losses.
    int                 ph[NUM_PLL];
    int                 age[NUM_PLL];
    int                 tries[NUM_PLL];
    int                 losses[NUM_PLL];
    logic [NUM_PLL-1:0] raw_log[MAXE];
    int                 edge_n = 0;
    int                 last_rst_edge = 0;
    logic [NUM_PLL-1:0] exp_rdy_prev = '0;

    logic [NUM_PLL-1:0] raw_v;
    logic [NUM_PLL-1:0] rc_v;
    logic               rst_v;
    int                 hold[NUM_PLL];

    task automatic model_edge(input logic [NUM_PLL-1:0] raw,
                              input logic [NUM_PLL-1:0] rc,
                              input logic r);
        exp_t e;
        logic lk;
        e = '0;
        raw_log[edge_n] = raw;
        if (r) begin
            last_rst_edge = edge_n;
            for (int c = 0; c < NUM_PLL; c++) begin
                ph[c] = PH_RST; age[c] = 0; tries[c] = 0; losses[c] = 0;
            end
            e.all = 1'b0;
        end else begin
            for (int c = 0; c < NUM_PLL; c++) begin
                // The FSM sees the raw flag as sampled SYNC_STAGES edges earlier.
                lk = (edge_n - SYNC_STAGES > last_rst_edge) ? raw_log[edge_n - SYNC_STAGES][c] : 1'b0;
                case (ph[c])
                    PH_RST: begin
                        age[c]++;
                        if (age[c] == PLL_RST_CYCLES) begin ph[c] = PH_WAIT; age[c] = 0; end
                    end
                    PH_WAIT: begin
                        if (lk) begin
                            ph[c] = PH_STABLE; age[c] = 0;
                        end else begin
                            age[c]++;
                            if (age[c] == LOCK_TIMEOUT_CYCLES) begin
                                tries[c]++;
                                age[c] = 0;
                                ph[c] = (tries[c] == MAX_RETRIES) ? PH_FAIL : PH_RST;
                            end
                        end
                    end
                    PH_STABLE: begin
                        if (!lk) begin
                            ph[c] = PH_WAIT; age[c] = 0;
                        end else begin
                            age[c]++;
                            if (age[c] == LOCK_STABLE_CYCLES) begin ph[c] = PH_LOCKED; age[c] = 0; end
                        end
                    end
                    PH_LOCKED: begin
                        if (!lk) begin
                            if (losses[c] < LOSS_SAT) losses[c]++;
                            tries[c] = 0; ph[c] = PH_RST; age[c] = 0;
                        end
                    end
                    PH_FAIL: begin
                        if (rc[c]) begin ph[c] = PH_RST; age[c] = 0; tries[c] = 0; end
                    end
                    default: ph[c] = PH_RST;
                endcase
            end
            e.all = &exp_rdy_prev;
        end
        for (int c = 0; c < NUM_PLL; c++) begin
            e.prst[c] = (ph[c] == PH_RST) || (ph[c] == PH_FAIL);
            e.rdy[c]  = (ph[c] == PH_LOCKED);
            e.fl[c]   = (ph[c] == PH_FAIL);
            e.loss[c*LOSS_CNT_W +: LOSS_CNT_W] = LOSS_CNT_W'(losses[c]);
        end
        exp_rdy_prev = e.rdy;
        exp_q.push_back(e);
        edge_n++;
    endtask

    task automatic tick();
        @(negedge refclk);
        pll_locked_in = raw_v;
        retry_clear   = rc_v;
        rst           = rst_v;
        model_edge(raw_v, rc_v, rst_v);
        rc_v = '0;
    endtask

    task automatic run_until(input int ch, input int p, input int limit);
        for (int i = 0; i < limit && ph[ch] != p; i++) tick();
    endtask

    task automatic drop0();
        run_until(0, PH_LOCKED, 200);
        raw_v[0] = 1'b0;
        tick();
        raw_v[0] = 1'b1;
        tick();
    endtask

    // Monitor: each edge the DUT presents a new output word; compare it to the oldest prediction.
    always @(posedge refclk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {pll_rst, clk_ready, fail, all_ready, loss_cnt};
            n_checks++;
            if (mon_got !== mon_e) begin
                n_errors++;
                $display("FAIL outputs t=%0t: got pll_rst=%b clk_ready=%b fail=%b all_ready=%b loss_cnt=%h, expected pll_rst=%b clk_ready=%b fail=%b all_ready=%b loss_cnt=%h",
                         $time, mon_got.prst, mon_got.rdy, mon_got.fl, mon_got.all, mon_got.loss,
                         mon_e.prst, mon_e.rdy, mon_e.fl, mon_e.all, mon_e.loss);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        raw_v = '0; rc_v = '0; rst_v = 1'b1;
        pll_locked_in = '0; retry_clear = '0; rst = 1'b1;
        for (int c = 0; c < NUM_PLL; c++) hold[c] = 0;
        repeat (3) tick();
        rst_v = 1'b0;

        // Clean lock on both channels, channel 0 three cycles into WAIT_LOCK.
        run_until(0, PH_WAIT, 50);
        repeat (3) tick();
        raw_v[0] = 1'b1;
        repeat (5) tick();
        raw_v[1] = 1'b1;
        run_until(1, PH_LOCKED, 100);
        repeat (4) tick();

        // Glitchy lock on channel 0 after a fresh reset.
        rst_v = 1'b1; raw_v = '0; tick(); rst_v = 1'b0;
        raw_v[1] = 1'b1;
        run_until(0, PH_WAIT, 50);
        raw_v[0] = 1'b1; repeat (10) tick();
        raw_v[0] = 1'b0; tick();
        raw_v[0] = 1'b1;
        run_until(0, PH_LOCKED, 100);
        repeat (4) tick();

        // Channel 1 never locks; retry_clear outside FAIL must be ignored.
        raw_v[1] = 1'b0;
        run_until(1, PH_WAIT, 50);
        rc_v[1] = 1'b1; tick();
        rc_v[0] = 1'b1; tick();
        run_until(1, PH_FAIL, 400);
        repeat (20) tick();

        // Recovery from FAIL.
        rc_v[1] = 1'b1; tick();
        run_until(1, PH_WAIT, 50);
        repeat (2) tick();
        raw_v[1] = 1'b1;
        run_until(1, PH_LOCKED, 100);
        repeat (4) tick();

        // Five losses, then reset while locked.
        repeat (5) drop0();
        run_until(0, PH_LOCKED, 200);
        repeat (3) tick();
        rst_v = 1'b1; tick(); rst_v = 1'b0;
        raw_v = '1;
        run_until(0, PH_LOCKED, 200);

        // 300 losses on channel 0 to saturate the counter.
        repeat (300) drop0();
        run_until(0, PH_LOCKED, 200);
        repeat (4) tick();

        // Randomized lock flags, retry pulses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_PLL; c++) begin
                if (hold[c] == 0) begin
                    raw_v[c] = 1'($urandom_range(0, 1));
                    hold[c]  = $urandom_range(1, 120);
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 39) == 0) rc_v = NUM_PLL'($urandom_range(0, (1 << NUM_PLL) - 1));
            rst_v = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst_v = 1'b0;
        tick();

        @(posedge refclk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Multi-channel lock supervisor that sits beside a bank of NUM_PLL PLL instances. All PLLs share one reference clock.
- Per channel it drives the PLL reset and qualifies the PLL's asynchronous locked output (synchronise, then debounce).
- It times out a failed lock and re-resets the PLL a bounded number of times, then declares failure.
- It publishes a per-channel clk_ready and a saturating loss-of-lock event count for the CSR block.

Parameters:
- NUM_PLL, 2, number of supervised PLL channels (1..16).
- SYNC_STAGES, 2, flops in each locked-input synchroniser (>=2).
- PLL_RST_CYCLES, 8, cycles pll_rst is held high per reset attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 64, cycles allowed in WAIT_LOCK before the attempt counts as failed.
- LOCK_STABLE_CYCLES, 16, consecutive synchronised-locked cycles required before clk_ready asserts.
- MAX_RETRIES, 3, failed attempts before the FAIL state (>=1).
- LOSS_CNT_W, 8, width of each loss-of-lock counter.

Ports:
- refclk  in  1  supervisor clock; free-running reference clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked_in  in  NUM_PLL  raw locked flags from the PLLs; asynchronous to refclk.
- retry_clear  in  NUM_PLL  single-cycle pulse; restarts a channel that is in FAIL.
- pll_rst  out  NUM_PLL  reset to each PLL; active high.
- clk_ready  out  NUM_PLL  channel output clock is locked and stable.
- all_ready  out  1  AND of clk_ready across all channels.
- fail  out  NUM_PLL  channel exhausted MAX_RETRIES.
- loss_cnt  out  NUM_PLL*LOSS_CNT_W  per-channel loss-of-lock count; channel i occupies bits [i*LOSS_CNT_W +: LOSS_CNT_W].

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Clock and reset ports are named refclk and rst.
- Every output is registered.
- Reset values: pll_rst all 1, clk_ready 0, all_ready 0, fail 0, loss_cnt 0. Every FSM is in RST_PLL with its timer at 0 and its retry count at 0. Synchroniser flops are cleared to 0.
- Each channel has an independent FSM. lk means the synchronised locked bit after SYNC_STAGES flops.
- RST_PLL:
  - pll_rst=1.
  - Move to WAIT_LOCK after exactly PLL_RST_CYCLES cycles in this state. The timer resets on entry.
- WAIT_LOCK:
  - pll_rst=0.
  - If lk=1, move to STABLE.
  - Otherwise, when the timer reaches LOCK_TIMEOUT_CYCLES-1, increment retries. If the new value equals MAX_RETRIES, move to FAIL; else move to RST_PLL.
  - If lk=1 and the timeout occur in the same cycle, lk wins.
- STABLE:
  - pll_rst=0.
  - If lk=0, move back to WAIT_LOCK with the timer restarted. This debounce drop is not a loss event.
  - After LOCK_STABLE_CYCLES consecutive lk=1 cycles, move to LOCKED.
- LOCKED:
  - clk_ready=1.
  - If lk=0, clk_ready drops on the next edge. Increment loss_cnt, saturating at all-ones with no wrap. Clear retries to 0. Move to RST_PLL.
- FAIL:
  - fail=1, pll_rst=1 held, clk_ready=0.
  - retry_clear[i] moves the channel to RST_PLL with retries=0 and fail cleared.
  - retry_clear in any other state is ignored.
- Latency (clean lock): clk_ready rises SYNC_STAGES+LOCK_STABLE_CYCLES cycles after the first refclk edge that samples pll_locked_in high in WAIT_LOCK.
- all_ready is registered one cycle after the clk_ready vector.
- rst asserted mid-operation returns every channel to its reset values on the next edge. loss_cnt is also cleared.
- Channels never interact except through all_ready.

Decomposition:
- Shared package pll_sup_pkg holds:
  - the state enum (RST_PLL, WAIT_LOCK, STABLE, LOCKED, FAIL);
  - a timer width function, clog2 of max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)+1.
- Sub-module pll_lock_chan contains one channel: synchroniser, FSM, timer, retry counter and loss counter.
- The top instantiates NUM_PLL copies in a generate loop and forms all_ready.

Test Plan:
All scenarios use defaults unless stated.
1. Clean lock: release rst, raise pll_locked_in[0] 3 cycles after pll_rst[0] falls -> pll_rst[0] high for 8 cycles; clk_ready[0] rises exactly 18 cycles after first sampled lock; all_ready rises one cycle after both channels are ready.
2. Glitchy lock: lock high 10 cycles, low 1 cycle, then high -> no clk_ready during the first burst; clk_ready rises 18 cycles after the final rise; loss_cnt stays 0.
3. Timeout and fail: hold pll_locked_in[1]=0 -> three pll_rst[1] pulses of 8 cycles, each followed by a 64-cycle wait; fail[1]=1 after the third timeout; pll_rst[1] stays high; channel 0 is unaffected.
4. Retry recovery: in FAIL, pulse retry_clear[1] and then provide lock -> fail[1] clears next cycle; new 8-cycle reset; clk_ready[1] asserts normally.
5. Loss of lock and saturation: from LOCKED, drop lock 300 times with LOSS_CNT_W=8 -> clk_ready falls one cycle after each sampled drop; loss_cnt[0] counts up to 255 and holds there.
6. Mid-operation reset: assert rst while channel 0 is in LOCKED with loss_cnt=5 -> next edge gives pll_rst=all 1, clk_ready=0, loss_cnt=0, fail=0.
